// File: rtl/riscv_regs_mp_if.sv
// Bundles the issue-side read/reserve ports and writeback ports of the register file.
// The master is the core pipeline; the slave is the register file.
interface riscv_regs_mp_if #(
  parameter int WORD_LENGTH = 32,
  parameter int ADDR_LENGTH = 5,
  parameter int NUM_REGS    = 32,
  parameter int NUM_READ    = 2,
  parameter int NUM_WRITE   = 2
);
  logic [NUM_READ*ADDR_LENGTH-1:0]  read_addr;
  logic [NUM_READ*WORD_LENGTH-1:0]  read_data;
  logic [NUM_READ-1:0]              read_ready;
  logic [NUM_WRITE-1:0]             write_en;
  logic [NUM_WRITE*ADDR_LENGTH-1:0] write_addr;
  logic [NUM_WRITE*WORD_LENGTH-1:0] write_data;
  logic                             rsv_en;
  logic [ADDR_LENGTH-1:0]           rsv_addr;
  logic                             rsv_stall;
  logic [NUM_REGS-1:0]              busy_vec;

  modport master (
    output read_addr, write_en, write_addr, write_data, rsv_en, rsv_addr,
    input  read_data, read_ready, rsv_stall, busy_vec
  );

  modport slave (
    input  read_addr, write_en, write_addr, write_data, rsv_en, rsv_addr,
    output read_data, read_ready, rsv_stall, busy_vec
  );
endinterface

// File: rtl/riscv_regs_mp.sv
// Multi-port integer register file with a per-register busy scoreboard and
// optional same-cycle writeback-to-read forwarding. x0 is hardwired to zero.
module riscv_regs_mp #(
  parameter int WORD_LENGTH = 32,
  parameter int ADDR_LENGTH = 5,
  parameter int NUM_REGS    = 32,
  parameter int NUM_READ    = 2,
  parameter int NUM_WRITE   = 2,
  parameter int BYPASS      = 1
) (
  input  logic           clk,
  input  logic           rst,
  riscv_regs_mp_if.slave bus
);
  localparam logic [ADDR_LENGTH:0] NUM_REGS_W = (ADDR_LENGTH+1)'(NUM_REGS);

  logic [WORD_LENGTH-1:0] r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]    r_busy;
  logic [NUM_REGS-1:0]    w_busy_next;

  logic [ADDR_LENGTH-1:0] w_wr_addr  [NUM_WRITE];
  logic [WORD_LENGTH-1:0] w_wr_data  [NUM_WRITE];
  logic [NUM_WRITE-1:0]   w_wr_valid;

  logic w_rsv_valid;
  logic w_rsv_wr_hit;
  logic w_rsv_stall;

  // A write is only real when it targets an existing, non-zero register.
  for (genvar gi = 0; gi < NUM_WRITE; gi++) begin : g_wr
    assign w_wr_addr[gi]  = bus.write_addr[gi*ADDR_LENGTH +: ADDR_LENGTH];
    assign w_wr_data[gi]  = bus.write_data[gi*WORD_LENGTH +: WORD_LENGTH];
    assign w_wr_valid[gi] = bus.write_en[gi] && (w_wr_addr[gi] != '0) &&
                            ({1'b0, w_wr_addr[gi]} < NUM_REGS_W);
  end

  always_comb begin
    w_rsv_valid  = bus.rsv_en && (bus.rsv_addr != '0) &&
                   ({1'b0, bus.rsv_addr} < NUM_REGS_W);
    w_rsv_wr_hit = 1'b0;
    for (int j = 0; j < NUM_WRITE; j++) begin
      if (w_wr_valid[j] && (w_wr_addr[j] == bus.rsv_addr)) begin
        w_rsv_wr_hit = 1'b1;
      end
    end
    w_rsv_stall = 1'b0;
    if (w_rsv_valid) begin
      w_rsv_stall = r_busy[bus.rsv_addr] && !w_rsv_wr_hit;
    end
  end

  // Writeback clears first, then an accepted reservation sets, so a new producer wins.
  always_comb begin
    w_busy_next = r_busy;
    for (int j = 0; j < NUM_WRITE; j++) begin
      if (w_wr_valid[j]) begin
        w_busy_next[w_wr_addr[j]] = 1'b0;
      end
    end
    if (w_rsv_valid && !w_rsv_stall) begin
      w_busy_next[bus.rsv_addr] = 1'b1;
    end
  end

  // Ascending port order gives the highest-index port priority on conflicts.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_regs[r] <= '0;
      end
      r_busy <= '0;
    end else begin
      for (int j = 0; j < NUM_WRITE; j++) begin
        if (w_wr_valid[j]) begin
          r_regs[w_wr_addr[j]] <= w_wr_data[j];
        end
      end
      r_busy <= w_busy_next;
    end
  end

  for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_rd
    logic [ADDR_LENGTH-1:0] w_addr;
    logic [WORD_LENGTH-1:0] w_data;
    logic                   w_ready;

    assign w_addr = bus.read_addr[gi*ADDR_LENGTH +: ADDR_LENGTH];

    always_comb begin
      w_data  = '0;
      w_ready = 1'b1;
      if ((w_addr != '0) && ({1'b0, w_addr} < NUM_REGS_W)) begin
        w_data  = r_regs[w_addr];
        w_ready = !r_busy[w_addr];
        if (BYPASS != 0) begin
          for (int j = 0; j < NUM_WRITE; j++) begin
            if (w_wr_valid[j] && (w_wr_addr[j] == w_addr)) begin
              w_data  = w_wr_data[j];
              w_ready = 1'b1;
            end
          end
        end
      end
    end

    assign bus.read_data[gi*WORD_LENGTH +: WORD_LENGTH] = w_data;
    assign bus.read_ready[gi]                           = w_ready;
  end

  assign bus.rsv_stall = w_rsv_stall;
  assign bus.busy_vec  = r_busy;
endmodule

// File: doc/riscv_regs_mp.md
Name: riscv_regs_mp

Overview:
- Parametrised multi-port integer register file with a per-register busy scoreboard and optional same-cycle write-to-read bypass.
- Sits between decode/issue (read and reserve ports) and writeback (write ports) of a pipelined or dual-issue RISC-V core.
- Supersedes the single-write / dual-read file: configurable port counts, full synchronous reset, hazard tracking.

Parameters:
- WORD_LENGTH, 32: register width in bits.
- ADDR_LENGTH, 5: register address width.
- NUM_REGS, 32: number of architectural registers. Must be ≤ 2**ADDR_LENGTH. Register 0 is hardwired to zero.
- NUM_READ, 2: number of read ports, 1..4.
- NUM_WRITE, 2: number of write ports, 1..2.
- BYPASS, 1: 1 = same-cycle writeback data is forwarded to reads; 0 = no forwarding.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous active-high reset.
- read_addr  input  NUM_READ*ADDR_LENGTH  packed read addresses; port i occupies bits [i*ADDR_LENGTH +: ADDR_LENGTH].
- read_data  output  NUM_READ*WORD_LENGTH  packed read data.
- read_ready  output  NUM_READ  1 = the corresponding read_data is architecturally valid (no pending write).
- write_en  input  NUM_WRITE  per-port write strobe.
- write_addr  input  NUM_WRITE*ADDR_LENGTH  packed write addresses.
- write_data  input  NUM_WRITE*WORD_LENGTH  packed write data.
- rsv_en  input  1  request to mark register rsv_addr busy (instruction issued with destination rsv_addr).
- rsv_addr  input  ADDR_LENGTH  destination register being reserved.
- rsv_stall  output  1  reservation refused this cycle (WAW hazard).
- busy_vec  output  NUM_REGS  current scoreboard bits, for debug and issue logic.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - rst is sampled on posedge clk. When high: all registers ← 0, all busy bits ← 0.
  - rst dominates any write or reservation in the same cycle.
- Reset values, from the first posedge with rst=1 onward:
  - read_data = 0 on all ports.
  - read_ready = all 1s.
  - rsv_stall = 0.
  - busy_vec = 0.
- Reads are combinational (zero latency):
  - Address 0 always returns 0 with ready=1.
  - Address ≥ NUM_REGS returns 0 with ready=1.
- Writes: registered on posedge when write_en[j]=1 and write_addr[j]≠0.
  - A write to 0 or an out-of-range address is ignored entirely (no data change, no busy change).
- Write conflict: two write ports enabled to the same address → the highest-index port wins. Both ports still clear that register's busy bit.
- Bypass, BYPASS=1:
  - If read_addr[i] matches any enabled, valid write_addr[j] in the same cycle, read_data[i] = write_data of the highest matching j, and read_ready[i]=1.
  - Otherwise read_data[i] = stored value and read_ready[i] = !busy[read_addr[i]].
- Bypass, BYPASS=0: read_data[i] = stored value and read_ready[i] = !busy[read_addr[i]], regardless of any same-cycle write.
- Scoreboard, per register r:
  - Set when rsv_en=1, rsv_addr=r, r≠0, r<NUM_REGS, and rsv_stall=0.
  - Cleared when any enabled write port targets r.
  - Same-cycle set and clear on the same r → the set wins; busy stays 1 for the new producer.
- rsv_stall (combinational) = rsv_en && busy[rsv_addr] && no enabled write to rsv_addr this cycle.
  - A stalled reservation changes no state; the issuer must hold and retry.
  - Reserving 0 or an out-of-range address never stalls and has no effect.
- Writes do not require a prior reservation. A write to a non-busy register just updates data.
- Reset mid-operation: pending busy bits are discarded. Writes already in flight upstream are the pipeline's responsibility to flush.
- No X propagation: every flop is written by reset. Unused packed bits are never indexed.

Test Plan:
- rst=1 for one cycle, then read x1..x31 on all ports → data 0, read_ready all 1s, busy_vec 0.
- Write 0xDEADBEEF to x5 on port0 with BYPASS=1, reading x5 in the same cycle → read_data=0xDEADBEEF, ready=1. Next cycle still reads 0xDEADBEEF. With BYPASS=0, same-cycle read returns the old value 0.
- Port0 writes x7=0x11 and port1 writes x7=0x22 in the same cycle → x7 reads 0x22 next cycle. Write to x0=0xFFFF → x0 reads 0.
- Reserve x3 → busy_vec[3]=1 and read_ready=0 on x3. Reserve x3 again → rsv_stall=1, no change. Write x3=0x5 → busy clears, ready=1, data 0x5.
- Same cycle: rsv_en on x9 (busy) while port1 writes x9 → rsv_stall=0, data updated, busy_vec[9] remains 1.
- Reserve x4, x6 and write x2=0xAB, then assert rst → next cycle all data 0 and busy_vec 0. A write asserted with rst is dropped.
